spi_flash_slave: RTL and testbench

- Cycle-based SPI NOR flash slave model that sits directly downstream of the APB-to-SPI bridge.
- Consumes its spi_sck/spi_ss[0]/spi_mosi pads and drives spi_miso back.
- Decodes the standard READ command (0x03 + 24-bit address) and streams bytes fetched from a word-wide backing memory port (simulation ROM or DPI wrapper).
- Runs on the system clock and oversamples sck; sck is generated from that same clock, so no synchronizers are needed.

---
 rtl/spi_flash_pkg.sv | 10 +
 rtl/spi_edge_det.sv | 19 +
 rtl/spi_flash_slave.sv | 131 +++++++++++++
 tb/tb_spi_flash_slave.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash slave model.
package spi_flash_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int MEM_AW_DEF = ADDR_W_DEF - 2;
  localparam logic [7:0] CMD_READ_DEF = 8'h03;
  localparam int BCNT_W = 5;  // holds 0..23 for the address phase
  localparam int BIB_W = 3;   // bit index within a byte

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
endpackage

// File: rtl/spi_edge_det.sv
// Registers sck and flags its rising/falling edges while the slave is selected.
module spi_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  output logic rise,
  output logic fall
);
  logic sck_q;

  always_ff @(posedge clock) begin
    if (reset) sck_q <= 1'b0;
    else       sck_q <= spi_sck;
  end

  assign rise = spi_sck & ~sck_q & ~spi_ss;
  assign fall = ~spi_sck & sck_q & ~spi_ss;
endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 NOR flash slave: decodes READ (0x03 + 24-bit address) and streams
// bytes fetched word-wise from a backing memory port.
module spi_flash_slave
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF,
  parameter int MEM_AW = ADDR_W - 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              cmd_err,
  output logic              busy
);
  state_t             state;
  logic               rise, fall;
  logic [6:0]         cmd_sr;
  logic [ADDR_W-2:0]  addr_sr;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [BIB_W-1:0]   bit_in_byte;
  logic [1:0]         byte_off;
  logic [31:0]        word_buf;
  logic               cap_pend;
  logic               miso_q;
  logic [7:0]         nxt_cmd;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [31:0]        src_word;
  logic [7:0]         cur_byte;

  spi_edge_det u_edge (
    .clock   (clock),
    .reset   (reset),
    .spi_sck (spi_sck),
    .spi_ss  (spi_ss),
    .rise    (rise),
    .fall    (fall)
  );

  // The fall right after a refill can land in the cycle the read data arrives,
  // so forward mem_rdata until word_buf has captured it.
  always_comb begin
    nxt_cmd  = {cmd_sr, spi_mosi};
    nxt_addr = {addr_sr, spi_mosi};
    src_word = cap_pend ? mem_rdata : word_buf;
    cur_byte = src_word[{byte_off, 3'b000} +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cmd_sr      <= '0;
      addr_sr     <= '0;
      bit_cnt     <= '0;
      bit_in_byte <= '0;
      byte_off    <= '0;
      word_buf    <= '0;
      cap_pend    <= 1'b0;
      miso_q      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cmd_err     <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      cmd_err  <= 1'b0;
      cap_pend <= mem_req;
      if (cap_pend && !spi_ss) word_buf <= mem_rdata;
      if (spi_ss) begin
        state       <= IDLE;
        miso_q      <= 1'b0;
        bit_cnt     <= '0;
        bit_in_byte <= '0;
        byte_off    <= '0;
        cap_pend    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            cmd_sr <= nxt_cmd[6:0];
            if (bit_cnt == BCNT_W'(7)) begin
              bit_cnt <= '0;
              if (nxt_cmd == CMD_READ) state <= ADDR;
              else begin
                cmd_err <= 1'b1;
                state   <= IGNORE;
              end
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          ADDR: if (rise) begin
            addr_sr <= nxt_addr[ADDR_W-2:0];
            if (bit_cnt == BCNT_W'(ADDR_W - 1)) begin
              mem_req     <= 1'b1;
              mem_addr    <= nxt_addr[ADDR_W-1:2];
              byte_off    <= nxt_addr[1:0];
              bit_in_byte <= '0;
              bit_cnt     <= '0;
              state       <= DATA;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
          DATA: begin
            if (fall) miso_q <= cur_byte[3'd7 - bit_in_byte];
            if (rise) begin
              bit_in_byte <= bit_in_byte + 1'b1;
              if (bit_in_byte == 3'd7) begin
                byte_off <= byte_off + 1'b1;
                if (byte_off == 2'd3) begin
                  mem_addr <= mem_addr + 1'b1;
                  mem_req  <= 1'b1;
                end
              end
            end
          end
          IGNORE: miso_q <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso = miso_q & ~spi_ss;
  assign busy     = ~spi_ss & (state != IDLE);
endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: drives mode-0 frames with a 4-clock sck.
module tb_spi_flash_slave;
  logic        clock, reset;
  logic        spi_sck, spi_ss, spi_mosi, spi_miso;
  logic        mem_req, cmd_err, busy;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int req_cnt, err_cnt, miso_hi, snap;
  logic [21:0] req_q[$];
  logic [31:0] mem [logic [21:0]];

  spi_flash_slave dut (
    .clock     (clock),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_ss    (spi_ss),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Backing memory: data valid the cycle after the request.
  always @(posedge clock)
    if (mem_req) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;

  always @(negedge clock) begin
    if (mem_req) begin
      req_cnt++;
      req_q.push_back(mem_addr);
    end
    if (cmd_err) err_cnt++;
    if (spi_miso) miso_hi++;
  end

  task automatic clr_mon();
    req_cnt = 0; err_cnt = 0; miso_hi = 0; snap = 0;
    req_q.delete();
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (2) @(negedge clock);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (2) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                           output logic [63:0] rx);
    logic [31:0] hdr;
    logic r;
    hdr = {cmd, addr};
    rx = '0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) snap = req_cnt;
      xfer_bit((i < 32) ? hdr[31-i] : 1'b0, r);
      rx = {rx[62:0], r};
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                           output logic [63:0] rx);
    spi_ss = 1'b0;
    repeat (2) @(negedge clock);
    send_bits(cmd, addr, n, rx);
    repeat (2) @(negedge clock);
    spi_ss = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_read_aligned();
    logic [63:0] rx;
    clr_mon();
    mem.delete();
    mem[22'h0] = 32'h44332211;
    run_frame(8'h03, 24'h000000, 64, rx);
    total++; if (rx[31:0] !== 32'h11223344) begin bad++; $display("FAIL aligned_data got=%h exp=11223344", rx[31:0]); end
    total++; if (rx[63:32] !== 32'h0) begin bad++; $display("FAIL aligned_hdr_miso got=%h exp=0", rx[63:32]); end
    total++; if (snap !== 1) begin bad++; $display("FAIL aligned_req_cnt got=%0d exp=1", snap); end
    total++; if (req_q.size() < 1 || req_q[0] !== 22'h0) begin bad++; $display("FAIL aligned_req_addr got=%h exp=0", (req_q.size() > 0) ? req_q[0] : 22'h3fffff); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL aligned_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_read_offset();
    logic [63:0] rx;
    clr_mon();
    mem.delete();
    mem[22'h0] = 32'h44332211;
    mem[22'h1] = 32'h88776655;
    run_frame(8'h03, 24'h000002, 64, rx);
    total++; if (rx[31:0] !== 32'h33445566) begin bad++; $display("FAIL offset_data got=%h exp=33445566", rx[31:0]); end
    total++; if (req_cnt !== 2) begin bad++; $display("FAIL offset_req_cnt got=%0d exp=2", req_cnt); end
    total++; if (req_q.size() < 2 || req_q[1] !== 22'h1) begin bad++; $display("FAIL offset_req2_addr got=%h exp=1", (req_q.size() > 1) ? req_q[1] : 22'h3fffff); end
  endtask

  task automatic test_bad_opcode();
    logic [63:0] rx;
    clr_mon();
    run_frame(8'h0B, 24'h000000, 64, rx);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL badop_cmd_err_cnt got=%0d exp=1", err_cnt); end
    total++; if (req_cnt !== 0) begin bad++; $display("FAIL badop_req_cnt got=%0d exp=0", req_cnt); end
    total++; if (miso_hi !== 0 || rx !== 64'h0) begin bad++; $display("FAIL badop_miso got=%0d/%h exp=0/0", miso_hi, rx); end
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    clr_mon();
    mem.delete();
    mem[22'h1] = 32'hDDCCBBAA;
    run_frame(8'h03, 24'h000004, 20, rx);
    total++; if (req_cnt !== 0) begin bad++; $display("FAIL abort_req_cnt got=%0d exp=0", req_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    clr_mon();
    run_frame(8'h03, 24'h000004, 64, rx);
    total++; if (rx[31:0] !== 32'hAABBCCDD) begin bad++; $display("FAIL abort_next_data got=%h exp=aabbccdd", rx[31:0]); end
    total++; if (snap !== 1 || req_q[0] !== 22'h1) begin bad++; $display("FAIL abort_next_req got=%0d@%h exp=1@1", snap, req_q[0]); end
  endtask

  task automatic test_reset_mid_data();
    logic [63:0] rx;
    clr_mon();
    mem.delete();
    mem[22'h0] = 32'hFFFFFFFF;
    spi_ss = 1'b0;
    repeat (2) @(negedge clock);
    send_bits(8'h03, 24'h000000, 44, rx);
    total++; if (busy !== 1'b1 || spi_miso !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b%b exp=11", busy, spi_miso); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b exp=0", spi_miso); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    spi_ss = 1'b1;
    repeat (3) @(negedge clock);
    mem[22'h0] = 32'h44332211;
    clr_mon();
    run_frame(8'h03, 24'h000000, 64, rx);
    total++; if (rx[31:0] !== 32'h11223344) begin bad++; $display("FAIL midrst_next_data got=%h exp=11223344", rx[31:0]); end
  endtask

  task automatic test_addr_wrap();
    logic [63:0] rx;
    clr_mon();
    mem.delete();
    mem[22'h3FFFFF] = 32'h04030201;
    mem[22'h0] = 32'h44332211;
    run_frame(8'h03, 24'hFFFFFC, 64, rx);
    total++; if (rx[31:0] !== 32'h01020304) begin bad++; $display("FAIL wrap_data got=%h exp=01020304", rx[31:0]); end
    total++; if (req_q.size() < 1 || req_q[0] !== 22'h3FFFFF) begin bad++; $display("FAIL wrap_req1 got=%h exp=3fffff", (req_q.size() > 0) ? req_q[0] : 22'h1); end
    total++; if (req_q.size() < 2 || req_q[1] !== 22'h0) begin bad++; $display("FAIL wrap_req2 got=%h exp=0", (req_q.size() > 1) ? req_q[1] : 22'h1); end
  endtask

  initial begin
    mem_rdata = 32'h0;
    clr_mon();
    test_reset();
    test_read_aligned();
    test_read_offset();
    test_bad_opcode();
    test_abort();
    test_reset_mid_data();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
